// File: rtl/versat_config_sequencer_pkg.sv
// Shared types and default widths for the Versat config sequencer.
// The defaults match the accelerator's config port widths.
package versat_config_sequencer_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned ADDR_W_DEF    = 5;
   localparam int unsigned TIMEOUT_W_DEF = 16;

   typedef enum logic [2:0] {
      StIdle,
      StScan,
      StWrite,
      StRun,
      StArm,
      StWaitDone,
      StFinish
   } state_e;

endpackage

// File: rtl/versat_dirty_prio_enc.sv
// Dirty bitmap for the shadow buffer.
// Reports the lowest dirty index at or above a base index.
module versat_dirty_prio_enc
   import versat_config_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_idx,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_idx,
   input  logic [ADDR_W:0]   base,
   output logic              found,
   output logic [ADDR_W-1:0] found_idx
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] dirty_q, dirty_d;

   always_comb begin
      dirty_d = dirty_q;
      if (set_en) dirty_d[set_idx] = 1'b1;
      if (clr_en) dirty_d[clr_idx] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dirty_q <= '0;
      else     dirty_q <= dirty_d;
   end

   // base carries one extra bit so that a base past the last entry matches nothing
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (dirty_q[i] && (i >= int'(base))) begin
            found     = 1'b1;
            found_idx = ADDR_W'(i);
         end
      end
   end

endmodule

// File: rtl/versat_config_sequencer.sv
// Shadows accelerator config words written by the host and replays dirty
// entries in ascending address order on start, then pulses run and awaits done.
module versat_config_sequencer
   import versat_config_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_valid,
   input  logic                host_we,
   input  logic [ADDR_W-1:0]   host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   output logic                host_ready,
   output logic [DATA_W-1:0]   host_rdata,
   input  logic                start,
   output logic                busy,
   output logic                seq_done,
   output logic                error,
   output logic                acc_valid,
   output logic [ADDR_W-1:0]   acc_addr,
   output logic [DATA_W/8-1:0] acc_wstrb,
   output logic [DATA_W-1:0]   acc_wdata,
   input  logic                acc_ready,
   output logic                acc_run,
   input  logic                acc_done
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_e               state_q, state_d;
   logic [ADDR_W:0]      idx_q, idx_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic                 error_q, error_d;
   logic [DATA_W-1:0]    shadow_q [DEPTH];

   logic              host_acc;
   logic              shadow_we;
   logic              wd_expired;
   logic              acc_accept;
   logic              found;
   logic [ADDR_W-1:0] found_idx;

   assign host_acc   = host_valid && (state_q == StIdle);
   assign shadow_we  = host_acc && host_we;
   assign host_ready = host_acc;
   assign host_rdata = host_acc ? shadow_q[host_addr] : '0;

   always_ff @(posedge clk) begin
      if (shadow_we) shadow_q[host_addr] <= host_wdata;
   end

   versat_dirty_prio_enc #(
      .ADDR_W (ADDR_W)
   ) u_dirty (
      .clk       (clk),
      .rst       (rst),
      .set_en    (shadow_we),
      .set_idx   (host_addr),
      .clr_en    (acc_accept),
      .clr_idx   (idx_q[ADDR_W-1:0]),
      .base      (idx_q),
      .found     (found),
      .found_idx (found_idx)
   );

   assign wd_expired = &wd_q;
   // Request is withdrawn in the expiry cycle so a late ready cannot be taken
   assign acc_valid  = (state_q == StWrite) && !wd_expired;
   assign acc_accept = acc_valid && acc_ready;
   assign acc_addr   = acc_valid ? idx_q[ADDR_W-1:0] : '0;
   assign acc_wdata  = acc_valid ? shadow_q[idx_q[ADDR_W-1:0]] : '0;
   assign acc_wstrb  = acc_valid ? {(DATA_W/8){1'b1}} : '0;
   assign acc_run    = (state_q == StRun);
   assign busy       = (state_q != StIdle);
   assign seq_done   = (state_q == StFinish);
   assign error      = error_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      error_d = error_q;
      wd_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               error_d = 1'b0;
               idx_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (found) begin
               idx_d   = {1'b0, found_idx};
               state_d = StWrite;
            end else begin
               state_d = StRun;
            end
         end
         StWrite: begin
            if (wd_expired) begin
               error_d = 1'b1;
               state_d = StFinish;
            end else if (acc_ready) begin
               idx_d   = idx_q + (ADDR_W + 1)'(1);
               state_d = StScan;
            end else begin
               wd_d = wd_q + TIMEOUT_W'(1);
            end
         end
         StRun: state_d = StArm;
         StArm: state_d = StWaitDone;
         StWaitDone: begin
            if (acc_done) begin
               state_d = StFinish;
            end else if (wd_expired) begin
               error_d = 1'b1;
               state_d = StFinish;
            end else begin
               wd_d = wd_q + TIMEOUT_W'(1);
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         wd_q    <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wd_q    <= wd_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_versat_config_sequencer.sv
// Randomised bench for versat_config_sequencer: plays host and accelerator,
// predicting replay order, handshakes and timing from a shadow/dirty model.
module tb_versat_config_sequencer;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int TIMEOUT_W = 4;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int WD_CYCLES = 1 << TIMEOUT_W;

   logic                clk = 1'b0;
   logic                rst;
   logic                host_valid, host_we;
   logic [ADDR_W-1:0]   host_addr;
   logic [DATA_W-1:0]   host_wdata;
   logic                host_ready;
   logic [DATA_W-1:0]   host_rdata;
   logic                start, busy, seq_done, error;
   logic                acc_valid;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W/8-1:0] acc_wstrb;
   logic [DATA_W-1:0]   acc_wdata;
   logic                acc_ready, acc_run, acc_done;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] m_shadow  [DEPTH];
   bit                m_dirty   [DEPTH];
   bit                m_written [DEPTH];

   versat_config_sequencer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .TIMEOUT_W (TIMEOUT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .host_valid (host_valid),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ready (host_ready),
      .host_rdata (host_rdata),
      .start      (start),
      .busy       (busy),
      .seq_done   (seq_done),
      .error      (error),
      .acc_valid  (acc_valid),
      .acc_addr   (acc_addr),
      .acc_wstrb  (acc_wstrb),
      .acc_wdata  (acc_wdata),
      .acc_ready  (acc_ready),
      .acc_run    (acc_run),
      .acc_done   (acc_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic host_write(input int addr, input logic [DATA_W-1:0] data);
      @(negedge clk);
      host_valid = 1'b1;
      host_we    = 1'b1;
      host_addr  = ADDR_W'(addr);
      host_wdata = data;
      #1 check_eq("host_ready_wr", 64'(host_ready), 64'd1);
      @(posedge clk);
      m_shadow[addr]  = data;
      m_dirty[addr]   = 1'b1;
      m_written[addr] = 1'b1;
      #1 host_valid = 1'b0;
   endtask

   task automatic host_read(input int addr);
      @(negedge clk);
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = ADDR_W'(addr);
      #1 check_eq("host_ready_rd", 64'(host_ready), 64'd1);
      if (m_written[addr]) check_eq("host_rdata", 64'(host_rdata), 64'(m_shadow[addr]));
      @(posedge clk);
      #1 host_valid = 1'b0;
   endtask

   // done_mode: 0 = done some cycles after run, 1 = done held high from before start,
   // 2 = done never arrives (watchdog expiry expected)
   task automatic run_seq(input int min_dly, input int max_dly, input int done_mode,
                          input bit wr_with_start);
      int  exp_q[$];
      int  cyc, wait_cnt, dly, run_cyc, runs, done_at, fin_cyc, first_valid, exp_fin;
      bit  prev_acc, finished, exp_err, had_writes;
      int  a;
      @(negedge clk);
      start    = 1'b1;
      acc_done = (done_mode == 1);
      if (wr_with_start) begin
         a          = $urandom_range(DEPTH - 1);
         host_valid = 1'b1;
         host_we    = 1'b1;
         host_addr  = ADDR_W'(a);
         host_wdata = $urandom;
         m_shadow[a]  = host_wdata;
         m_dirty[a]   = 1'b1;
         m_written[a] = 1'b1;
      end
      #1 check_eq("busy_before_start", 64'(busy), 64'd0);
      if (wr_with_start) check_eq("host_ready_with_start", 64'(host_ready), 64'd1);
      for (int i = 0; i < DEPTH; i++) if (m_dirty[i]) exp_q.push_back(i);
      had_writes = (exp_q.size() != 0);
      exp_err    = (done_mode == 2);
      @(posedge clk);
      #1 start = 1'b0;
      host_valid = 1'b0;
      cyc = 0; run_cyc = -1; runs = 0; finished = 0; prev_acc = 0; wait_cnt = 0;
      fin_cyc = -1; first_valid = -1; done_at = 1 << 30;
      dly = $urandom_range(max_dly, min_dly);
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         acc_ready  = 1'b0;
         start      = 1'($urandom_range(1));
         host_valid = 1'($urandom_range(1));
         host_we    = 1'($urandom_range(1));
         host_addr  = ADDR_W'($urandom_range(DEPTH - 1));
         host_wdata = $urandom;
         if (done_mode == 0 && cyc >= done_at) acc_done = 1'b1;
         #1;
         check_eq("host_stall", 64'(host_ready), 64'd0);
         check_eq("busy", 64'(busy), 64'd1);
         if (cyc == 1) check_eq("error_cleared", 64'(error), 64'd0);
         if (prev_acc) check_eq("gap_after_ready", 64'(acc_valid), 64'd0);
         prev_acc = 1'b0;
         if (acc_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_write", 64'(acc_valid), 64'd0);
            end else begin
               check_eq("acc_addr", 64'(acc_addr), 64'(exp_q[0]));
               check_eq("acc_wdata", 64'(acc_wdata), 64'(m_shadow[exp_q[0]]));
               check_eq("acc_wstrb", 64'(acc_wstrb), 64'({(DATA_W/8){1'b1}}));
               if (wait_cnt == dly) begin
                  acc_ready = 1'b1;
                  prev_acc  = 1'b1;
               end else begin
                  wait_cnt++;
               end
            end
         end
         if (acc_run) begin
            runs++;
            check_eq("run_pending_writes", 64'(exp_q.size()), 64'd0);
            run_cyc = cyc;
            done_at = cyc + 1 + $urandom_range(4);
         end
         if (seq_done) begin
            finished = 1'b1;
            fin_cyc  = cyc;
            check_eq("error_at_done", 64'(error), 64'(exp_err));
         end
         @(posedge clk);
         if (acc_ready && exp_q.size() != 0) begin
            m_dirty[exp_q[0]] = 1'b0;
            void'(exp_q.pop_front());
            wait_cnt = 0;
            dly      = $urandom_range(max_dly, min_dly);
         end
      end
      check_eq("seq_done_seen", 64'(finished), 64'd1);
      check_eq("run_count", 64'(runs), 64'd1);
      if (had_writes) check_eq("first_write_latency", 64'(first_valid), 64'd2);
      else check_eq("start_to_run_latency", 64'(run_cyc), 64'd2);
      if (done_mode == 2) exp_fin = run_cyc + 2 + WD_CYCLES;
      else if (done_mode == 1) exp_fin = run_cyc + 3;
      else exp_fin = ((run_cyc + 2 > done_at) ? run_cyc + 2 : done_at) + 1;
      check_eq("finish_cycle", 64'(fin_cyc), 64'(exp_fin));
      @(negedge clk);
      start      = 1'b0;
      acc_done   = 1'b0;
      acc_ready  = 1'b0;
      host_valid = 1'b0;
      #1 check_eq("busy_after_done", 64'(busy), 64'd0);
      check_eq("error_sticky", 64'(error), 64'(exp_err));
      check_eq("seq_done_pulse", 64'(seq_done), 64'd0);
   endtask

   initial begin
      rst = 1'b1; host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      start = 0; acc_ready = 0; acc_done = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_dirty[i] = 0; m_written[i] = 0; m_shadow[i] = '0;
      end
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_acc_valid", 64'(acc_valid), 64'd0);
      check_eq("rst_acc_run", 64'(acc_run), 64'd0);
      check_eq("rst_seq_done", 64'(seq_done), 64'd0);
      check_eq("rst_error", 64'(error), 64'd0);
      check_eq("rst_host_ready", 64'(host_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic replay order, including the last entry
      host_write(3, 32'h11);
      host_write(1, 32'h22);
      host_write(DEPTH - 1, 32'hCAFE_F00D);
      host_read(3);
      host_read(1);
      run_seq(0, 0, 0, 0);

      // Slow accelerator ready
      host_write(7, 32'hA5A5_0007);
      host_write(2, 32'h0000_0002);
      run_seq(5, 5, 0, 0);

      // Nothing dirty, stale done
      run_seq(0, 0, 1, 0);

      // Done never arrives, then a normal run clears error
      run_seq(0, 0, 2, 0);
      host_write(9, 32'h9999_0009);
      run_seq(0, 2, 0, 0);

      // Write in the same cycle as start
      run_seq(0, 1, 0, 1);

      // Reset mid-write
      host_write(4, 32'h4444);
      host_write(12, 32'hC0C0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 10 && !acc_valid; k++) begin
         @(negedge clk);
         #1;
      end
      check_eq("reset_reached_write", 64'(acc_valid), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_acc_valid", 64'(acc_valid), 64'd0);
      check_eq("rst_mid_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         m_dirty[i] = 0; m_written[i] = 0;
      end
      run_seq(0, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 6; n++) begin
         for (int w = 0; w < 1 + $urandom_range(5); w++)
            host_write($urandom_range(DEPTH - 1), $urandom);
         for (int r = 0; r < 3; r++) host_read($urandom_range(DEPTH - 1));
         run_seq(0, 4, $urandom_range(1), 1'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
